// File: rtl/mem_access_stage.sv
// EX/MEM -> MEM/WB pipeline stage: data-memory access, load return,
// sticky access-fault capture and saturating load/store counters.
module mem_access_stage #(
  parameter int WORD_SHIFT = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [31:0]      ex_alu,
  input  logic [7:0]       ex_store_data,
  input  logic             ex_is_load,
  input  logic             ex_is_store,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             stall,
  input  logic             flush,
  output logic [7:0]       dm_address,
  output logic             dm_wren,
  output logic [7:0]       dm_w_data,
  input  logic [7:0]       dm_r_data,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] ld_count,
  output logic [CNT_W-1:0] st_count
);

  localparam logic [31:0] LO_MASK = (32'd1 << WORD_SHIFT) - 32'd1;

  logic             is_mem;
  logic             bad;
  logic             adv;
  logic             good_ld;
  logic             good_st;

  logic             wb_valid_d, wb_valid_q;
  logic             wb_reg_write_d, wb_reg_write_q;
  logic [4:0]       wb_rd_d, wb_rd_q;
  logic [31:0]      wb_data_d, wb_data_q;
  logic             fault_d, fault_q;
  logic [31:0]      fault_addr_d, fault_addr_q;
  logic [CNT_W-1:0] ld_cnt_d, ld_cnt_q;
  logic [CNT_W-1:0] st_cnt_d, st_cnt_q;

  always_comb begin
    is_mem  = ex_is_load | ex_is_store;
    bad     = ((ex_alu & LO_MASK) != 32'd0)
            | ((ex_alu >> (WORD_SHIFT + 8)) != 32'd0)
            | (ex_is_load & ex_is_store);
    adv     = !stall && !flush;
    good_ld = ex_is_load & !bad;
    good_st = ex_is_store & !bad;
  end

  assign dm_address = ex_alu[WORD_SHIFT+7:WORD_SHIFT];
  assign dm_w_data  = ex_store_data;
  assign dm_wren    = !(ex_valid & good_st & adv & !rst);

  always_comb begin
    wb_valid_d     = wb_valid_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    fault_d        = fault_q;
    fault_addr_d   = fault_addr_q;
    ld_cnt_d       = ld_cnt_q;
    st_cnt_d       = st_cnt_q;
    if (flush) begin
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
    end else if (!stall) begin
      wb_valid_d     = ex_valid & !(bad & is_mem);
      wb_reg_write_d = ex_reg_write & wb_valid_d;
      wb_rd_d        = ex_rd;
      wb_data_d      = good_ld ? {24'h0, dm_r_data} : ex_alu;
      // Only the first fault's address is kept.
      if (ex_valid && is_mem && bad) begin
        fault_d = 1'b1;
        if (!fault_q) fault_addr_d = ex_alu;
      end
      if (ex_valid && good_ld && ld_cnt_q != '1)
        ld_cnt_d = ld_cnt_q + CNT_W'(1);
      if (ex_valid && good_st && st_cnt_q != '1)
        st_cnt_d = st_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= 32'd0;
      fault_q        <= 1'b0;
      fault_addr_q   <= 32'd0;
      ld_cnt_q       <= '0;
      st_cnt_q       <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      fault_q        <= fault_d;
      fault_addr_q   <= fault_addr_d;
      ld_cnt_q       <= ld_cnt_d;
      st_cnt_q       <= st_cnt_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign fault        = fault_q;
  assign fault_addr   = fault_addr_q;
  assign ld_count     = ld_cnt_q;
  assign st_count     = st_cnt_q;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter WORD_SHIFT, default 2, giving the byte-to-word address shift.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the access counters.
REQ-003 Port clk  in  1  system clock; all state updates on the rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port ex_valid  in  1  the EX/MEM input holds a real instruction.
REQ-006 Port ex_alu  in  32  ALU result: byte address for loads/stores, result value otherwise.
REQ-007 Port ex_store_data  in  8  store data.
REQ-008 Ports ex_is_load, ex_is_store, ex_reg_write  in  1 each  instruction class and register-write flag.
REQ-009 Port ex_rd  in  5  destination register.
REQ-010 Ports stall, flush  in  1 each  hazard-unit controls.
REQ-011 Port dm_address  out  8  word index to data memory.
REQ-012 Port dm_wren  out  1  data-memory write enable, active-low (0 = write).
REQ-013 Port dm_w_data  out  8  data-memory write data.
REQ-014 Port dm_r_data  in  8  data-memory combinational read data.
REQ-015 Ports wb_valid, wb_reg_write  out  1 each; wb_rd  out  5; wb_data  out  32  MEM/WB register.
REQ-016 Ports fault  out  1  and fault_addr  out  32  sticky access fault and address of the first fault.
REQ-017 Ports ld_count, st_count  out  CNT_W  committed load and store counts.

Function
REQ-018 dm_address SHALL be combinational: ex_alu[WORD_SHIFT+7:WORD_SHIFT].
REQ-019 dm_w_data SHALL equal ex_store_data combinationally.
REQ-020 A memory op is bad if ex_alu[WORD_SHIFT-1:0] != 0, ex_alu[31:WORD_SHIFT+8] != 0, or ex_is_load and ex_is_store are both 1.
REQ-021 The block SHALL drive dm_wren = 0 only when all hold: ex_valid, ex_is_store, !bad, !stall, !flush, !rst; otherwise dm_wren = 1.
REQ-022 Advance condition: !stall and !flush; each rising edge with advance set loads the MEM/WB register.
REQ-023 On advance: wb_valid = ex_valid & !(bad & (ex_is_load | ex_is_store)); wb_rd = ex_rd; wb_reg_write = ex_reg_write & wb_valid.
REQ-024 wb_data: for a good load, {24'b0, dm_r_data}; for a non-memory op, ex_alu; for a store, ex_alu.
REQ-025 Load-to-use latency SHALL be one cycle: load data appears at wb_data on the edge that accepts the load.
REQ-026 On flush (flush has priority over stall): wb_valid = 0, wb_reg_write = 0, no write, no counter change; wb_data/wb_rd are don't-care.
REQ-027 On stall without flush: all registers, including counters and fault state, SHALL hold, and no write occurs.
REQ-028 A valid bad memory op on an advancing edge SHALL set fault = 1; if fault was 0, fault_addr = ex_alu.
REQ-029 Later faults SHALL NOT change fault_addr; fault stays 1 until reset.
REQ-030 ld_count/st_count SHALL increment by 1 on each advancing edge with a valid good load/store, saturating at all-ones (no wrap).
REQ-031 A store followed immediately by a load to the same word SHALL return the stored value; memory write and read ordering is handled by the data memory write on the same edge.

Reset
REQ-032 While rst = 1: wb_valid = 0, wb_reg_write = 0, wb_rd = 0, wb_data = 0, fault = 0, fault_addr = 0, ld_count = 0, st_count = 0, dm_wren = 1.
REQ-033 Reset asserted mid-access SHALL suppress the write in that cycle; the first advance after rst falls uses the current inputs.

Verification
REQ-034 Store ex_alu=0x208, data 0x02, then load ex_alu=0x208 -> dm_address=0x82, dm_wren=0 for one cycle; load gives wb_data=0x00000002, st_count=1, ld_count=1.
REQ-035 Store to ex_alu=0x20A -> dm_wren stays 1, wb_valid=0, fault=1, fault_addr=0x0000020A; a later bad access to 0x400 leaves fault_addr at 0x20A.
REQ-036 Store with stall=1 for 3 cycles, then stall=0 -> exactly one write cycle (after release); wb outputs held during stall.
REQ-037 Load with flush=1 and stall=1 together -> wb_valid=0, ld_count unchanged, dm_wren=1.
REQ-038 Non-memory op ex_alu=0x12345678, rd=5, reg_write=1 -> next edge wb_data=0x12345678, wb_rd=5, wb_reg_write=1; rst pulse mid-stream -> all outputs reach REQ-032 values without a clock edge.
REQ-039 Run 2^CNT_W + 3 loads -> ld_count holds at all-ones.
